// File: rtl/izh_neuron_array.sv
// izh_neuron_array: N Izhikevich neurons time-multiplexed over one fixed-point Euler datapath.
// A step_start pulse in idle updates neurons 0..N-1, one per cycle, then pulses step_done.
// Optional build macro IZH_SAT_EN: every reduction to a narrower word saturates instead of
// wrapping (two's-complement wrap when undefined).
module izh_neuron_array #(
   parameter int unsigned N        = 4,
   parameter int unsigned W        = 21,
   parameter int unsigned FRAC     = 9,
   parameter int unsigned DT_SHIFT = 0,
   parameter int          A_DEF    = 10,
   parameter int          B_DEF    = 102,
   parameter int          C_DEF    = -33280,
   parameter int          D_DEF    = 4096,
   parameter int          V_PEAK   = 15360,
   parameter int          U_INIT   = -6656,
   localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             set,
   input  logic             step_start,
   input  logic [N*W-1:0]   I_vec,
   input  logic             cfg_we,
   input  logic [IW-1:0]    cfg_idx,
   input  logic [2:0]       cfg_sel,
   input  logic [W-1:0]     cfg_data,
   input  logic [IW-1:0]    mon_sel,
   output logic             step_busy,
   output logic             step_done,
   output logic [N-1:0]     spike_vec,
   output logic [W-1:0]     mon_v,
   output logic [W-1:0]     mon_u
);

   localparam int unsigned WG = W + 4;   // guarded sum width
   localparam int unsigned W2 = 2 * W;   // full product width

   typedef logic signed [W-1:0]  word_t;
   typedef logic signed [WG-1:0] gword_t;
   typedef logic signed [W2-1:0] dword_t;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

   localparam word_t  A_RST  = word_t'(A_DEF);
   localparam word_t  B_RST  = word_t'(B_DEF);
   localparam word_t  C_RST  = word_t'(C_DEF);
   localparam word_t  D_RST  = word_t'(D_DEF);
   localparam word_t  U_RST  = word_t'(U_INIT);
   localparam word_t  V_PK   = word_t'(V_PEAK);
   localparam gword_t K_DV   = gword_t'(71680);   // 140.0 in Q(FRAC)

   localparam gword_t G_MAX   = {1'b0, {(WG-1){1'b1}}};
   localparam gword_t G_MIN   = ~G_MAX;
   localparam dword_t G_MAX_D = dword_t'(G_MAX);
   localparam dword_t G_MIN_D = dword_t'(G_MIN);
   localparam word_t  W_MAX   = {1'b0, {(W-1){1'b1}}};
   localparam word_t  W_MIN   = ~W_MAX;
   localparam gword_t W_MAX_G = gword_t'(W_MAX);
   localparam gword_t W_MIN_G = gword_t'(W_MIN);

   // Reduce a full product-width value to the guarded sum width.
   function automatic gword_t red_g(dword_t x);
`ifdef IZH_SAT_EN
      if (x > G_MAX_D) return G_MAX;
      if (x < G_MIN_D) return G_MIN;
`endif
      return gword_t'(x);
   endfunction

   // Reduce a guarded sum to the storage word width.
   function automatic word_t red_w(gword_t x);
`ifdef IZH_SAT_EN
      if (x > W_MAX_G) return W_MAX;
      if (x < W_MIN_G) return W_MIN;
`endif
      return word_t'(x);
   endfunction

   function automatic gword_t sx(word_t x);
      return gword_t'(x);
   endfunction

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          last;

   word_t v_q [N];
   word_t u_q [N];
   word_t a_q [N];
   word_t b_q [N];
   word_t c_q [N];
   word_t d_q [N];
   word_t i_arr [N];

   logic [N-1:0] spk_q, spk_nx, spike_q;

   word_t  vc, uc, ac, bc, cc, dc, ic;
   dword_t vv, sq, sq20, t1, bv, bvs, ax, axs;
   gword_t vx, ux, ix, dv, vn_g, diff_g, du, un_g, ud_g;
   word_t  vn, diff, un, ud, v_wr, u_wr;
   logic   fire;
   logic   cfg_ok;

   // Unpack the per-neuron input currents.
   always_comb begin
      for (int k = 0; k < N; k++) begin
         i_arr[k] = I_vec[k*W +: W];
      end
   end

   // Shared update datapath for the neuron selected by idx_q.
   always_comb begin
      vc = v_q[idx_q];
      uc = u_q[idx_q];
      ac = a_q[idx_q];
      bc = b_q[idx_q];
      cc = c_q[idx_q];
      dc = d_q[idx_q];
      ic = i_arr[idx_q];

      vx = sx(vc);
      ux = sx(uc);
      ix = sx(ic);

      vv   = dword_t'(vc) * dword_t'(vc);
      sq   = vv >>> FRAC;
      sq20 = (sq <<< 4) + (sq <<< 2);
      t1   = sq20 >>> FRAC;
      dv   = red_g(t1) + (vx <<< 2) + vx + K_DV - ux + ix;
      vn_g = vx + (dv >>> DT_SHIFT);
      vn   = red_w(vn_g);

      bv     = dword_t'(bc) * dword_t'(vc);
      bvs    = bv >>> FRAC;
      diff_g = red_g(bvs) - ux;
      diff   = red_w(diff_g);
      ax     = dword_t'(ac) * dword_t'(diff);
      axs    = ax >>> FRAC;
      du     = red_g(axs);
      un_g   = ux + (du >>> DT_SHIFT);
      un     = red_w(un_g);

      ud_g = sx(un) + sx(dc);
      ud   = red_w(ud_g);

      fire = (vn >= V_PK);
      v_wr = fire ? cc : vn;
      u_wr = fire ? ud : un;

      spk_nx        = spk_q;
      spk_nx[idx_q] = fire;
   end

   // Next-state and status decode for the step sequencer.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last      = (idx_q == IW'(N - 1));
      step_busy = 1'b0;
      step_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (step_start) begin
               state_d = StCalc;
               idx_d   = '0;
            end
         end
         StCalc: begin
            step_busy = 1'b1;
            if (last) begin
               state_d = StDone;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         StDone: begin
            step_done = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Sequencer state and neuron index.
   always_ff @(posedge clk or posedge set) begin
      if (set) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Spikes collect in a shadow and become visible only as the step completes.
   always_ff @(posedge clk or posedge set) begin
      if (set) begin
         spk_q   <= '0;
         spike_q <= '0;
      end else if (state_q == StIdle && step_start) begin
         spk_q <= '0;
      end else if (state_q == StCalc) begin
         spk_q <= spk_nx;
         if (last) spike_q <= spk_nx;
      end
   end

   assign spike_vec = spike_q;
   assign cfg_ok    = (32'(cfg_idx) < N);

   // Neuron state: datapath write-back during a step, config writes only when idle.
   always_ff @(posedge clk or posedge set) begin
      if (set) begin
         for (int k = 0; k < N; k++) begin
            v_q[k] <= C_RST;
            u_q[k] <= U_RST;
            a_q[k] <= A_RST;
            b_q[k] <= B_RST;
            c_q[k] <= C_RST;
            d_q[k] <= D_RST;
         end
      end else if (state_q == StCalc) begin
         v_q[idx_q] <= v_wr;
         u_q[idx_q] <= u_wr;
      end else if (state_q == StIdle && cfg_we && cfg_ok) begin
         case (cfg_sel)
            3'd0:    a_q[cfg_idx] <= cfg_data;
            3'd1:    b_q[cfg_idx] <= cfg_data;
            3'd2:    c_q[cfg_idx] <= cfg_data;
            3'd3:    d_q[cfg_idx] <= cfg_data;
            3'd4:    v_q[cfg_idx] <= cfg_data;
            3'd5:    u_q[cfg_idx] <= cfg_data;
            default: ;
         endcase
      end
   end

   // Combinational monitor read of the stored state.
   always_comb begin
      mon_v = '0;
      mon_u = '0;
      if (32'(mon_sel) < N) begin
         mon_v = v_q[mon_sel];
         mon_u = u_q[mon_sel];
      end
   end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Bench for izh_neuron_array: integer reference model feeding a scoreboard, a cycle table for
// step timing, and hand sequences for spike, config ordering, saturation and mid-step reset.
module tb_izh_neuron_array;

   localparam int N  = 4;
   localparam int W  = 21;
   localparam int IW = 2;
   localparam int DT = 0;

   logic           clk = 1'b1;
   logic           set;
   logic           step_start;
   logic [N*W-1:0] I_vec;
   logic           cfg_we;
   logic [IW-1:0]  cfg_idx;
   logic [2:0]     cfg_sel;
   logic [W-1:0]   cfg_data;
   logic [IW-1:0]  mon_sel;
   logic           step_busy;
   logic           step_done;
   logic [N-1:0]   spike_vec;
   logic [W-1:0]   mon_v;
   logic [W-1:0]   mon_u;

   izh_neuron_array dut (
      .clk        (clk),
      .set        (set),
      .step_start (step_start),
      .I_vec      (I_vec),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_sel    (cfg_sel),
      .cfg_data   (cfg_data),
      .mon_sel    (mon_sel),
      .step_busy  (step_busy),
      .step_done  (step_done),
      .spike_vec  (spike_vec),
      .mon_v      (mon_v),
      .mon_u      (mon_u)
   );

   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   longint mv [N];
   longint mu [N];
   longint ma [N];
   longint mb [N];
   longint mc [N];
   longint md [N];
   logic [N-1:0] last_model_spk;

   logic [N-1:0] q_spk [$];
   longint       q_v [$];
   longint       q_u [$];

   typedef struct {
      logic start;
      logic accept;
      logic busy;
      logic done;
   } tvec_t;
   tvec_t tv [9];

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   function automatic longint wrapb(input longint x, input int bits);
      longint m;
      longint r;
      m = longint'(1) <<< bits;
      r = x & (m - 1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   function automatic longint red(input longint x, input int bits);
`ifdef IZH_SAT_EN
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (bits - 1)) - 1;
      lo = -hi - 1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
`else
      return wrapb(x, bits);
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = -33280;
         mu[i] = -6656;
         ma[i] = 10;
         mb[i] = 102;
         mc[i] = -33280;
         md[i] = 4096;
      end
      q_spk.delete();
      q_v.delete();
      q_u.delete();
   endtask

   task automatic model_cfg(input int idx, input int sel, input longint data);
      case (sel)
         0: ma[idx] = data;
         1: mb[idx] = data;
         2: mc[idx] = data;
         3: md[idx] = data;
         4: mv[idx] = data;
         5: mu[idx] = data;
         default: ;
      endcase
   endtask

   // Advance the model by one step with the current I_vec and queue the expected outcome.
   task automatic model_step_push();
      logic signed [W-1:0] iw;
      longint v, u, ii, sq, t1, dv, vn, bvs, x, du, un;
      logic [N-1:0] spk;
      spk = '0;
      for (int i = 0; i < N; i++) begin
         iw  = I_vec[i*W +: W];
         ii  = iw;
         v   = mv[i];
         u   = mu[i];
         sq  = (v * v) >>> 9;
         t1  = (20 * sq) >>> 9;
         dv  = wrapb(red(t1, 25) + 5 * v + 71680 - u + ii, 25);
         vn  = red(wrapb(v + (dv >>> DT), 25), 21);
         bvs = (mb[i] * v) >>> 9;
         x   = red(wrapb(red(bvs, 25) - u, 25), 21);
         du  = red((ma[i] * x) >>> 9, 25);
         un  = red(wrapb(u + (du >>> DT), 25), 21);
         if (vn >= 15360) begin
            mv[i]  = mc[i];
            mu[i]  = red(un + md[i], 21);
            spk[i] = 1'b1;
         end else begin
            mv[i] = vn;
            mu[i] = un;
         end
      end
      last_model_spk = spk;
      q_spk.push_back(spk);
      for (int i = 0; i < N; i++) begin
         q_v.push_back(mv[i]);
         q_u.push_back(mu[i]);
      end
   endtask

   task automatic read_mon(input int i, output longint v, output longint u);
      mon_sel = IW'(i);
      #1;
      v = longint'($signed(mon_v));
      u = longint'($signed(mon_u));
   endtask

   task automatic check_pop();
      logic [N-1:0] es;
      longint ev, eu, av, au;
      chk("sb_depth", longint'(q_spk.size() > 0), 1);
      if (q_spk.size() > 0) begin
         es = q_spk.pop_front();
         chk("spike_vec", longint'(spike_vec), longint'(es));
         for (int i = 0; i < N; i++) begin
            ev = q_v.pop_front();
            eu = q_u.pop_front();
            read_mon(i, av, au);
            chk($sformatf("v[%0d]", i), av, ev);
            chk($sformatf("u[%0d]", i), au, eu);
         end
      end
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!step_done && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!step_done) chk("done_timeout", longint'(step_done), 1);
      else check_pop();
   endtask

   task automatic run_step(input bit push);
      @(negedge clk);
      step_start = 1'b1;
      if (push) model_step_push();
      @(negedge clk);
      step_start = 1'b0;
      wait_done();
   endtask

   task automatic cfg(input int idx, input int sel, input longint data);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_idx  = IW'(idx);
      cfg_sel  = 3'(sel);
      cfg_data = W'(data);
      model_cfg(idx, sel, data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic set_i(input int i, input longint val);
      I_vec[i*W +: W] = W'(val);
   endtask

   initial begin
      longint av, au;
      int spk_dut, spk_model;

      // cycle-by-cycle step timing: start accepted at c0's edge, retry at c2 must be ignored
      tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0};
      tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tv[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1};
      tv[6] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0};

      n_vec      = 0;
      n_err      = 0;
      set        = 1'b1;
      step_start = 1'b0;
      I_vec      = '0;
      cfg_we     = 1'b0;
      cfg_idx    = '0;
      cfg_sel    = '0;
      cfg_data   = '0;
      mon_sel    = '0;
      model_reset();
      #15 set = 1'b0;

      // reset state
      for (int i = 0; i < N; i++) begin
         read_mon(i, av, au);
         chk($sformatf("rst_v[%0d]", i), av, -33280);
         chk($sformatf("rst_u[%0d]", i), au, -6656);
      end
      chk("rst_spike", longint'(spike_vec), 0);
      chk("rst_busy", longint'(step_busy), 0);
      chk("rst_done", longint'(step_done), 0);

      // single spike on neuron 2, hand-derived results
      cfg(2, 4, 15000);
      set_i(2, 7680);
      run_step(1'b1);
      chk("spike_hand", longint'(spike_vec), 4);
      read_mon(2, av, au);
      chk("spk_v2", av, -33280);
      chk("spk_u2", au, -2372);
      read_mon(0, av, au);
      chk("rest_v0", av, -36844);
      chk("rest_u0", au, -6656);

      // config write and start in the same idle cycle: the step sees the written v
      set_i(0, 7680);
      @(negedge clk);
      cfg_we     = 1'b1;
      cfg_idx    = 2'd0;
      cfg_sel    = 3'd4;
      cfg_data   = W'(15000);
      step_start = 1'b1;
      model_cfg(0, 4, 15000);
      model_step_push();
      @(negedge clk);
      cfg_we     = 1'b0;
      step_start = 1'b0;
      wait_done();
      chk("cfg_first_spk0", longint'(spike_vec[0]), 1);

      // step timing table
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         chk($sformatf("tbl_busy[%0d]", c), longint'(step_busy), longint'(tv[c].busy));
         chk($sformatf("tbl_done[%0d]", c), longint'(step_done), longint'(tv[c].done));
         if (step_done) check_pop();
         step_start = tv[c].start;
         if (tv[c].accept) model_step_push();
      end
      @(negedge clk);
      step_start = 1'b0;
      chk("tbl_sb_empty", longint'(q_spk.size()), 0);

      // config write while busy must be dropped (neuron 0 already updated by then)
      @(negedge clk);
      step_start = 1'b1;
      model_step_push();
      @(negedge clk);
      step_start = 1'b0;
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_idx  = 2'd0;
      cfg_sel  = 3'd4;
      cfg_data = W'(1234);
      @(negedge clk);
      cfg_we = 1'b0;
      wait_done();

      // mixed classes: FS-like neuron 1, all driven with +15
      cfg(1, 0, 51);
      cfg(1, 2, -25600);
      cfg(1, 3, 1024);
      for (int i = 0; i < N; i++) set_i(i, 7680);
      spk_dut   = 0;
      spk_model = 0;
      for (int s = 0; s < 1000; s++) begin
         run_step(1'b1);
         spk_dut   += int'(spike_vec[1]);
         spk_model += int'(last_model_spk[1]);
      end
      chk("fs_spike_count", longint'(spk_dut), longint'(spk_model));

      // saturation / wrap of u + d on a spiking neuron
      cfg(0, 0, 0);
      cfg(0, 4, 15000);
      cfg(0, 5, 1048000);
      cfg(0, 3, 4096);
      set_i(0, 1048575);
      run_step(1'b1);
      chk("sat_spk0", longint'(spike_vec[0]), 1);
      read_mon(0, av, au);
      chk("sat_v0", av, -33280);
`ifdef IZH_SAT_EN
      chk("sat_u0", au, 1048575);
`else
      chk("sat_u0", au, -1045056);
`endif

      // reset asserted in the second busy cycle
      @(negedge clk);
      step_start = 1'b1;
      @(negedge clk);
      step_start = 1'b0;
      @(negedge clk);
      set = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      set = 1'b0;
      for (int i = 0; i < N; i++) begin
         read_mon(i, av, au);
         chk($sformatf("mrst_v[%0d]", i), av, -33280);
         chk($sformatf("mrst_u[%0d]", i), au, -6656);
      end
      chk("mrst_spike", longint'(spike_vec), 0);
      chk("mrst_busy", longint'(step_busy), 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("mrst_nodone[%0d]", c), longint'(step_done), 0);
      end
      I_vec = '0;
      run_step(1'b1);
      read_mon(0, av, au);
      chk("mrst_after_v0", av, -36844);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
